imu_mpu_sched: RTL and testbench

- Sequencer that drives a byte-level I2C master for the MPU-6050-class IMU on the board.
- After reset it waits a power-up delay, then wakes the sensor with the write PWR_MGMT_1 (0x6B) <= 0x00.
- It then runs a periodic 14-byte burst read from ACCEL_XOUT_H (0x3B) and publishes a coherent snapshot of accel, temperature and gyro to the I/O device registers.
- NACKs are counted, retried with backoff, and flagged.

---
 rtl/imu_mpu_sched.sv | 278 +++++++++++++++++++++++++++
 tb/tb_imu_mpu_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_mpu_sched.sv
// imu_mpu_sched: wakes an MPU-6050-class IMU, then runs periodic 14-byte burst reads over a
// byte-level I2C master and publishes coherent accel/temp/gyro snapshots with NACK retry/fault.
module imu_mpu_sched #(
  parameter logic [6:0]  DEV_ADDR      = 7'h68,
  parameter int unsigned PERIOD_CYCLES = 100000,
  parameter int unsigned INIT_DELAY    = 200000,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_rdata,
  input  logic        rsp_nack,
  input  logic        enable,
  input  logic        clear_fault,
  output logic [31:0] readdata_0,
  output logic [31:0] readdata_1,
  output logic [31:0] readdata_2,
  output logic [31:0] readdata_3,
  output logic [31:0] readdata_4,
  output logic [31:0] readdata_5,
  output logic [31:0] readdata_6,
  output logic [31:0] readdata_7,
  output logic [31:0] readdata_8,
  output logic        sample_strobe
);

  localparam int unsigned PER_W   = 24;
  localparam int unsigned DLY_W   = 32;
  localparam int unsigned RTY_W   = 8;
  localparam int unsigned NBYTES  = 14;
  localparam int unsigned BACKOFF = (PERIOD_CYCLES / 4 > 0) ? PERIOD_CYCLES / 4 : 1;

  localparam logic [PER_W-1:0] PER_LAST     = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [DLY_W-1:0] INIT_LAST_CY = DLY_W'(INIT_DELAY - 1);
  localparam logic [DLY_W-1:0] BACK_LAST_CY = DLY_W'(BACKOFF - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX    = RTY_W'(MAX_RETRY);

  localparam logic [3:0] S_PWRUP    = 4'd0;
  localparam logic [3:0] S_INIT     = 4'd1;
  localparam logic [3:0] S_WAIT     = 4'd2;
  localparam logic [3:0] S_RD       = 4'd3;
  localparam logic [3:0] S_COMMIT   = 4'd4;
  localparam logic [3:0] S_ERR_STOP = 4'd5;
  localparam logic [3:0] S_BACKOFF  = 4'd6;
  localparam logic [3:0] S_FAULT    = 4'd7;

  localparam logic [2:0] OP_START   = 3'd0;
  localparam logic [2:0] OP_RESTART = 3'd1;
  localparam logic [2:0] OP_WRITE   = 3'd2;
  localparam logic [2:0] OP_RD_ACK  = 3'd3;
  localparam logic [2:0] OP_RD_NACK = 3'd4;
  localparam logic [2:0] OP_STOP    = 3'd5;

  localparam logic [4:0] INIT_LAST  = 5'd4;
  localparam logic [4:0] RD_LAST    = 5'd19;
  localparam logic [4:0] RD_BYTE0   = 5'd5;
  localparam logic [7:0] ADDR_W     = {DEV_ADDR, 1'b0};
  localparam logic [7:0] ADDR_R     = {DEV_ADDR, 1'b1};

  logic [3:0]       state, state_n;
  logic [4:0]       step, step_n;
  logic             cmd_valid_n, pending, pending_n;
  logic [2:0]       op_n;
  logic [7:0]       wdata_n;
  logic [DLY_W-1:0] dly, dly_n;
  logic [PER_W-1:0] per_cnt, per_n;
  logic [RTY_W-1:0] retry, retry_n;
  logic [7:0]       nack_cnt, nack_n;
  logic             init_done, init_done_n, sticky, sticky_n, strobe_n;
  logic [31:0]      sample_cnt, cnt_n;
  logic [7:0]       shadow [NBYTES];
  logic [7:0]       shadow_n [NBYTES];
  logic [31:0]      sample [7];
  logic [31:0]      sample_n [7];
  logic             go_txn, go_rd, done;
  logic [3:0]       byte_idx;

  // Command table: step index within INIT or RD transaction -> {op, wdata}.
  function automatic logic [10:0] cmd_for(input logic is_rd, input logic [4:0] s);
    logic [10:0] c;
    c = {OP_RD_ACK, 8'h00};
    if (!is_rd) begin
      case (s)
        5'd0:    c = {OP_START, 8'h00};
        5'd1:    c = {OP_WRITE, ADDR_W};
        5'd2:    c = {OP_WRITE, 8'h6B};
        5'd3:    c = {OP_WRITE, 8'h00};
        default: c = {OP_STOP, 8'h00};
      endcase
    end else begin
      case (s)
        5'd0:    c = {OP_START, 8'h00};
        5'd1:    c = {OP_WRITE, ADDR_W};
        5'd2:    c = {OP_WRITE, 8'h3B};
        5'd3:    c = {OP_RESTART, 8'h00};
        5'd4:    c = {OP_WRITE, ADDR_R};
        5'd18:   c = {OP_RD_NACK, 8'h00};
        5'd19:   c = {OP_STOP, 8'h00};
        default: c = {OP_RD_ACK, 8'h00};
      endcase
    end
    return c;
  endfunction

  function automatic logic [31:0] sext16(input logic [7:0] h, input logic [7:0] l);
    return {{16{h[7]}}, h, l};
  endfunction

  assign done     = pending && rsp_valid;
  assign byte_idx = 4'(step - RD_BYTE0);

  always_comb begin
    state_n     = state;
    step_n      = step;
    cmd_valid_n = cmd_valid;
    op_n        = cmd_op;
    wdata_n     = cmd_wdata;
    pending_n   = pending;
    dly_n       = dly;
    per_n       = (per_cnt == PER_LAST) ? per_cnt : per_cnt + 1'b1;
    retry_n     = retry;
    nack_n      = nack_cnt;
    init_done_n = init_done;
    sticky_n    = sticky;
    cnt_n       = sample_cnt;
    strobe_n    = 1'b0;
    shadow_n    = shadow;
    sample_n    = sample;
    go_txn      = 1'b0;
    go_rd       = 1'b0;

    // One command in flight: drop valid on accept, then wait for the response.
    if (cmd_valid && cmd_ready) begin
      cmd_valid_n = 1'b0;
      pending_n   = 1'b1;
    end

    case (state)
      S_PWRUP: begin
        if (dly == INIT_LAST_CY) go_txn = 1'b1;
        else                     dly_n  = dly + 1'b1;
      end
      S_INIT, S_RD: begin
        if (done) begin
          pending_n = 1'b0;
          if (rsp_nack) begin
            nack_n      = (nack_cnt == 8'hFF) ? nack_cnt : nack_cnt + 8'd1;
            retry_n     = retry + 8'd1;
            state_n     = S_ERR_STOP;
            cmd_valid_n = 1'b1;
            op_n        = OP_STOP;
            wdata_n     = 8'h00;
          end else begin
            if (state == S_RD && (cmd_op == OP_RD_ACK || cmd_op == OP_RD_NACK))
              shadow_n[byte_idx] = rsp_rdata;
            if (state == S_INIT && step == INIT_LAST) begin
              init_done_n = 1'b1;
              retry_n     = '0;
              state_n     = S_WAIT;
            end else if (state == S_RD && step == RD_LAST) begin
              state_n = S_COMMIT;
            end else begin
              step_n            = 5'(step + 5'd1);
              cmd_valid_n       = 1'b1;
              {op_n, wdata_n}   = cmd_for(state == S_RD, 5'(step + 5'd1));
            end
          end
        end
      end
      S_ERR_STOP: begin
        if (done) begin
          pending_n = 1'b0;
          dly_n     = '0;
          state_n   = (retry >= RETRY_MAX) ? S_FAULT : S_BACKOFF;
        end
      end
      S_BACKOFF: begin
        if (dly == BACK_LAST_CY) begin
          go_txn = 1'b1;
          go_rd  = init_done;
        end else begin
          dly_n = dly + 1'b1;
        end
      end
      S_WAIT: begin
        if (per_cnt == PER_LAST && enable) begin
          go_txn = 1'b1;
          go_rd  = 1'b1;
        end
      end
      S_COMMIT: begin
        sample_n[0] = sext16(shadow[0],  shadow[1]);
        sample_n[1] = sext16(shadow[2],  shadow[3]);
        sample_n[2] = sext16(shadow[4],  shadow[5]);
        sample_n[3] = sext16(shadow[6],  shadow[7]);
        sample_n[4] = sext16(shadow[8],  shadow[9]);
        sample_n[5] = sext16(shadow[10], shadow[11]);
        sample_n[6] = sext16(shadow[12], shadow[13]);
        cnt_n       = sample_cnt + 32'd1;
        strobe_n    = 1'b1;
        sticky_n    = 1'b1;
        retry_n     = '0;
        state_n     = S_WAIT;
      end
      S_FAULT: begin
        if (clear_fault) begin
          retry_n = '0;
          if (init_done) state_n = S_WAIT;
          else           go_txn  = 1'b1;
        end
      end
      default: state_n = S_PWRUP;
    endcase

    // Every transaction (first attempt or retry) begins by presenting START.
    if (go_txn) begin
      state_n         = go_rd ? S_RD : S_INIT;
      step_n          = '0;
      cmd_valid_n     = 1'b1;
      {op_n, wdata_n} = cmd_for(go_rd, 5'd0);
      if (go_rd) per_n = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_PWRUP;
      step          <= '0;
      cmd_valid     <= 1'b0;
      cmd_op        <= 3'd0;
      cmd_wdata     <= 8'h00;
      pending       <= 1'b0;
      dly           <= '0;
      per_cnt       <= '0;
      retry         <= '0;
      nack_cnt      <= '0;
      init_done     <= 1'b0;
      sticky        <= 1'b0;
      sample_cnt    <= '0;
      sample_strobe <= 1'b0;
      shadow        <= '{default: '0};
      sample        <= '{default: '0};
    end else begin
      state         <= state_n;
      step          <= step_n;
      cmd_valid     <= cmd_valid_n;
      cmd_op        <= op_n;
      cmd_wdata     <= wdata_n;
      pending       <= pending_n;
      dly           <= dly_n;
      per_cnt       <= per_n;
      retry         <= retry_n;
      nack_cnt      <= nack_n;
      init_done     <= init_done_n;
      sticky        <= sticky_n;
      sample_cnt    <= cnt_n;
      sample_strobe <= strobe_n;
      shadow        <= shadow_n;
      sample        <= sample_n;
    end
  end

  assign readdata_0 = sample[0];
  assign readdata_1 = sample[1];
  assign readdata_2 = sample[2];
  assign readdata_3 = sample[3];
  assign readdata_4 = sample[4];
  assign readdata_5 = sample[5];
  assign readdata_6 = sample[6];
  assign readdata_7 = sample_cnt;
  assign readdata_8 = {12'd0, state, nack_cnt, 5'd0, init_done, (state == S_FAULT), sticky};

endmodule

// File: tb/tb_imu_mpu_sched.sv
// Directed bench for imu_mpu_sched: an I2C byte-master model answers commands while the main
// sequence checks wake-up, burst reads, coherence, stalls, retries, fault, period, enable and reset.
module tb_imu_mpu_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_rdata = 8'h00;
  logic        rsp_nack = 1'b0;
  logic        enable = 1'b1;
  logic        clear_fault = 1'b0;
  logic [31:0] readdata_0, readdata_1, readdata_2, readdata_3, readdata_4;
  logic [31:0] readdata_5, readdata_6, readdata_7, readdata_8;
  logic        sample_strobe;

  imu_mpu_sched #(.DEV_ADDR(7'h68), .PERIOD_CYCLES(500), .INIT_DELAY(10), .MAX_RETRY(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .enable(enable), .clear_fault(clear_fault),
    .readdata_0(readdata_0), .readdata_1(readdata_1), .readdata_2(readdata_2),
    .readdata_3(readdata_3), .readdata_4(readdata_4), .readdata_5(readdata_5),
    .readdata_6(readdata_6), .readdata_7(readdata_7), .readdata_8(readdata_8),
    .sample_strobe(sample_strobe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Byte-master model state
  int          cyc = 0;
  logic        busy = 1'b0;
  int          lat = 0;
  logic [7:0]  cur_rdata = 8'h00;
  logic        cur_nack = 1'b0;
  int          rd_idx = 0;
  logic [7:0]  rd_bytes [14];
  int          nack_left = 0;
  int          stall_left = 0;
  logic [2:0]  stall_op = 3'd1;
  logic [7:0]  stall_dat = 8'h00;
  logic        stalling = 1'b0;
  int          stall_bad = 0;
  int          stall_seen = 0;
  logic [10:0] log_q [$];
  int          start_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (!reset_n) begin
        busy = 1'b0; cmd_ready = 1'b0; stalling = 1'b0;
      end else begin
        if (cmd_ready) cmd_ready = 1'b0;
        if (busy) begin
          if (lat == 0) begin
            rsp_valid = 1'b1; rsp_rdata = cur_rdata; rsp_nack = cur_nack; busy = 1'b0;
          end else lat--;
        end else if (stall_left > 0 && (stalling || (cmd_valid && cmd_op == stall_op))) begin
          if (!stalling) begin stalling = 1'b1; stall_dat = cmd_wdata; end
          if (!(cmd_valid === 1'b1 && cmd_op === stall_op && cmd_wdata === stall_dat)) stall_bad++;
          stall_seen++;
          stall_left--;
          if (stall_left == 0) stalling = 1'b0;
        end else if (cmd_valid) begin
          cmd_ready = 1'b1; busy = 1'b1; lat = 1;
          log_q.push_back({cmd_op, cmd_wdata});
          cur_nack = 1'b0; cur_rdata = 8'h00;
          case (cmd_op)
            3'd0: begin rd_idx = 0; start_q.push_back(cyc); end
            3'd2: if (cmd_wdata == 8'hD0 && nack_left > 0) begin cur_nack = 1'b1; nack_left--; end
            3'd3, 3'd4: begin
              if (rd_idx < 14) cur_rdata = rd_bytes[rd_idx];
              rd_idx++;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Output monitor: snapshot registers may only change together with sample_strobe.
  logic [223:0] prev_snap = '0;
  logic [223:0] cur_snap;
  logic [6:0]   mask, last_mask = '0;
  int           bad_change = 0;
  int           strobe_cnt = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      cur_snap = {readdata_6, readdata_5, readdata_4, readdata_3, readdata_2, readdata_1, readdata_0};
      if (reset_n) begin
        for (int i = 0; i < 7; i++) mask[i] = (cur_snap[i*32 +: 32] != prev_snap[i*32 +: 32]);
        if (mask != 7'd0 && !sample_strobe) bad_change++;
        if (sample_strobe) begin strobe_cnt++; last_mask = mask; end
      end
      prev_snap = cur_snap;
    end
  end

  task automatic wait_strobe(input string tag, input int budget);
    int n = 0;
    while (!sample_strobe && n < budget) begin @(posedge clk); #1; n++; end
    check({tag, "_strobe"}, 32'(sample_strobe), 32'd1);
  endtask

  task automatic wait_status(input string tag, input int bitn, input int budget);
    int n = 0;
    while (!readdata_8[bitn] && n < budget) begin @(posedge clk); #1; n++; end
    check(tag, 32'(readdata_8[bitn]), 32'd1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n = 0;
    while (!(cmd_valid && cmd_op == 3'd0) && n < budget) begin @(posedge clk); #1; n++; end
    check(tag, 32'(cmd_valid && cmd_op == 3'd0), 32'd1);
  endtask

  task automatic check_init_log(input string tag);
    check({tag, "_len"}, 32'(log_q.size()), 32'd5);
    check({tag, "_0"}, 32'(log_q[0][10:8]), 32'd0);
    check({tag, "_1"}, 32'(log_q[1]), 32'({3'd2, 8'hD0}));
    check({tag, "_2"}, 32'(log_q[2]), 32'({3'd2, 8'h6B}));
    check({tag, "_3"}, 32'(log_q[3]), 32'({3'd2, 8'h00}));
    check({tag, "_4"}, 32'(log_q[4][10:8]), 32'd5);
  endtask

  int gap;
  int cv_cnt;

  initial begin
    for (int i = 0; i < 14; i++) rd_bytes[i] = 8'(i + 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd0", readdata_0, 32'd0);
    check("rst_rd7", readdata_7, 32'd0);
    check("rst_status", readdata_8, 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Wake write
    wait_status("init_done", 2, 300);
    check_init_log("init");
    log_q.delete(); start_q.delete();

    // First burst read: bytes 0x01..0x0E
    wait_strobe("rd1", 1500);
    check("rd1_rd0", readdata_0, 32'h0000_0102);
    check("rd1_rd1", readdata_1, 32'h0000_0304);
    check("rd1_rd3", readdata_3, 32'h0000_0708);
    check("rd1_rd6", readdata_6, 32'h0000_0D0E);
    check("rd1_rd7", readdata_7, 32'd1);
    check("rd1_sticky", 32'(readdata_8[0]), 32'd1);
    check("rd1_len", 32'(log_q.size()), 32'd20);
    check("rd1_addrw", 32'(log_q[1]), 32'({3'd2, 8'hD0}));
    check("rd1_reg", 32'(log_q[2]), 32'({3'd2, 8'h3B}));
    check("rd1_restart", 32'(log_q[3][10:8]), 32'd1);
    check("rd1_addrr", 32'(log_q[4]), 32'({3'd2, 8'hD1}));
    check("rd1_ack13", 32'(log_q[17][10:8]), 32'd3);
    check("rd1_nack14", 32'(log_q[18][10:8]), 32'd4);
    check("rd1_stop", 32'(log_q[19][10:8]), 32'd5);
    @(posedge clk); #1;
    check("rd1_strobe_pulse", 32'(sample_strobe), 32'd0);
    check("rd1_strobe_cnt", 32'(strobe_cnt), 32'd1);

    // Sign extension and coherence
    rd_bytes = '{8'hFF, 8'h38, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h00, 8'h00,
                 8'h12, 8'h34, 8'h80, 8'h01, 8'hFE, 8'hDC};
    log_q.delete();
    wait_strobe("rd2", 1000);
    check("rd2_rd0", readdata_0, 32'hFFFF_FF38);
    check("rd2_rd1", readdata_1, 32'hFFFF_8000);
    check("rd2_rd2", readdata_2, 32'h0000_7FFF);
    check("rd2_rd4", readdata_4, 32'h0000_1234);
    check("rd2_rd6", readdata_6, 32'hFFFF_FEDC);
    check("rd2_rd7", readdata_7, 32'd2);
    @(posedge clk); #1;
    check("rd2_all_change", 32'(last_mask), 32'h7F);
    check("period_500", 32'(start_q[1] - start_q[0]), 32'd500);

    // cmd_ready held low on RESTART
    log_q.delete();
    stall_op = 3'd1; stall_left = 20;
    wait_strobe("stall", 1000);
    check("stall_seen", 32'(stall_seen), 32'd20);
    check("stall_stable", 32'(stall_bad), 32'd0);
    check("stall_rd7", readdata_7, 32'd3);
    check("stall_rd0", readdata_0, 32'hFFFF_FF38);
    check("stall_len", 32'(log_q.size()), 32'd20);
    check("stall_addrr", 32'(log_q[4]), 32'({3'd2, 8'hD1}));

    // Single NACK, backoff, successful retry
    @(posedge clk); #1;
    log_q.delete(); start_q.delete();
    nack_left = 1;
    wait_strobe("retry", 2000);
    check("retry_nack_cnt", 32'(readdata_8[15:8]), 32'd1);
    check("retry_rd7", readdata_7, 32'd4);
    check("retry_fault", 32'(readdata_8[1]), 32'd0);
    check("retry_stop", 32'(log_q[2][10:8]), 32'd5);
    check("retry_restart", 32'(log_q[3][10:8]), 32'd0);
    gap = start_q[1] - start_q[0];
    check("backoff_gap", 32'(gap >= 125 && gap < 200), 32'd1);

    // Three consecutive NACKs -> FAULT, then clear_fault
    @(posedge clk); #1;
    nack_left = 3;
    wait_status("fault_set", 1, 3000);
    check("fault_nack_cnt", 32'(readdata_8[15:8]), 32'd4);
    cv_cnt = 0;
    repeat (1000) begin @(posedge clk); #1; if (cmd_valid) cv_cnt++; end
    check("fault_silent", 32'(cv_cnt), 32'd0);
    check("fault_hold", 32'(readdata_8[1]), 32'd1);
    @(negedge clk) clear_fault = 1'b1;
    @(negedge clk) clear_fault = 1'b0;
    @(posedge clk); #1;
    check("fault_cleared", 32'(readdata_8[1]), 32'd0);
    wait_strobe("post_fault", 1500);
    check("post_fault_rd7", readdata_7, 32'd5);
    check("no_partial_update", 32'(bad_change), 32'd0);

    // enable dropped mid-read
    @(posedge clk); #1;
    wait_start("en_start", 1000);
    repeat (20) @(posedge clk);
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    wait_strobe("en", 1000);
    check("en_rd7", readdata_7, 32'd6);
    log_q.delete();
    repeat (1200) @(posedge clk);
    #1;
    check("en_idle", 32'(log_q.size()), 32'd0);

    // Reset mid-read
    @(negedge clk) enable = 1'b1;
    @(posedge clk); #1;
    wait_start("rst_start", 1000);
    repeat (30) @(posedge clk);
    @(negedge clk) reset_n = 1'b0;
    #1;
    check("mid_rst_rd0", readdata_0, 32'd0);
    check("mid_rst_rd7", readdata_7, 32'd0);
    check("mid_rst_status", readdata_8, 32'd0);
    check("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("mid_rst_strobe", 32'(sample_strobe), 32'd0);
    repeat (3) @(posedge clk);
    log_q.delete();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    wait_status("reinit_done", 2, 300);
    check_init_log("reinit");
    check("reinit_rd7", readdata_7, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
